sprite_draw_scheduler: RTL and testbench

//  Shares one colored-number sprite ROM (30x30 px, 8-bit pixels, addr 0..899) among N_REQ draw

---
 rtl/sprite_draw_scheduler_pkg.sv | 38 +++
 rtl/sprite_draw_scheduler_rr_arbiter.sv | 58 +++++
 rtl/sprite_draw_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_sprite_draw_scheduler.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_draw_scheduler_pkg.sv
// Shared definitions for the sprite draw scheduler: sprite geometry,
// ROM addressing, colour codes, pixel type and FSM state encoding.
package sprite_draw_scheduler_pkg;

  // Sprite geometry and ROM addressing
  localparam int SPR_W  = 30;
  localparam int SPR_H  = 30;
  localparam int FRAME  = SPR_W * SPR_H;
  localparam int ADDR_W = 10;

  // Column/row counter widths, sized from the sprite geometry
  localparam int COL_W = $clog2(SPR_W);
  localparam int ROW_W = $clog2(SPR_H);

  // Terminal values held at counter width so compares are width-exact
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FRAME - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(SPR_W - 1);

  // ROM colour select codes
  typedef enum logic [1:0] {
    COLOR_RED    = 2'd0,
    COLOR_GREEN  = 2'd1,
    COLOR_BLUE   = 2'd2,
    COLOR_YELLOW = 2'd3
  } color_e;

  // One sprite pixel as stored in the ROM and written to the framebuffer
  typedef logic [7:0] pixel_t;

  // Draw sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/sprite_draw_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant of the first active
// request at or after the pointer (wrapping); the pointer moves to the
// slot after the winner when the grant is taken.
module sprite_draw_scheduler_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_advance,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_grant_idx,
  output logic [IDX_W-1:0] o_ptr
);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_sel;
  logic             w_found;
  int               w_idx;

  // Scan upward from the pointer, wrapping, and pick the first active request
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_idx       = 0;
    w_sel       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= N_REQ) begin
        w_idx = w_idx - N_REQ;
      end
      w_sel = IDX_W'(w_idx);
      if (!w_found && i_req[w_sel]) begin
        w_found        = 1'b1;
        o_grant[w_sel] = 1'b1;
        o_grant_idx    = w_sel;
      end
    end
  end

  // Pointer update: the slot after the winner gets first chance next time
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      if (o_grant_idx == IDX_W'(N_REQ - 1)) begin
        r_ptr <= '0;
      end else begin
        r_ptr <= o_grant_idx + 1'b1;
      end
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/sprite_draw_scheduler.sv
// Sprite draw scheduler: shares one 30x30 numbered-sprite ROM among
// N_REQ requesters, scans the granted sprite row-major and forwards each
// pixel to a framebuffer write port with valid/ready flow control.
// Build option: define SPRITE_KEY_EN to suppress writes of pixels equal
// to KEY (transparent colour); the scan then never waits on those pixels.
module sprite_draw_scheduler
  import sprite_draw_scheduler_pkg::*;
#(
  parameter int     N_REQ = 4,
  parameter int     X_W   = 10,
  parameter int     Y_W   = 10,
  parameter pixel_t KEY   = 8'h00
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N_REQ-1:0]     i_req_valid,
  input  logic [2*N_REQ-1:0]   i_req_color,
  input  logic [2*N_REQ-1:0]   i_req_number,
  input  logic [X_W*N_REQ-1:0] i_req_x,
  input  logic [Y_W*N_REQ-1:0] i_req_y,
  output logic [N_REQ-1:0]     o_req_done,
  output logic [1:0]           o_rom_color,
  output logic [1:0]           o_rom_number,
  output logic [ADDR_W-1:0]    o_rom_addr,
  input  pixel_t               i_rom_data,
  output logic                 o_fb_we,
  input  logic                 i_fb_ready,
  output logic [X_W-1:0]       o_fb_x,
  output logic [Y_W-1:0]       o_fb_y,
  output pixel_t               o_fb_data,
  output logic                 o_busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Per-requester views of the packed request buses
  logic [1:0]     w_req_color  [N_REQ];
  logic [1:0]     w_req_number [N_REQ];
  logic [X_W-1:0] w_req_x      [N_REQ];
  logic [Y_W-1:0] w_req_y      [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign w_req_color[gi]  = i_req_color[2*gi +: 2];
    assign w_req_number[gi] = i_req_number[2*gi +: 2];
    assign w_req_x[gi]      = i_req_x[X_W*gi +: X_W];
    assign w_req_y[gi]      = i_req_y[Y_W*gi +: Y_W];
  end

  // Sequencer state and latched request
  state_e           r_state;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] r_req_done;
  logic             r_busy;
  color_e           r_color;
  logic [1:0]       r_number;
  logic [X_W-1:0]   r_base_x;
  logic [Y_W-1:0]   r_base_y;

  // Issue stage: address driven to the ROM this cycle and its position
  logic [ADDR_W-1:0] r_addr;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;

  // Stage p1: the pixel whose ROM data is on i_rom_data this cycle
  logic              r_p1_valid;
  logic [ADDR_W-1:0] r_p1_addr;
  logic [X_W-1:0]    r_fb_x;
  logic [Y_W-1:0]    r_fb_y;

  logic              w_any_req;
  logic              w_take;
  logic              w_fb_we;
  logic              w_advance;
  logic [N_REQ-1:0]  w_grant;
  logic [IDX_W-1:0]  w_grant_idx;
  logic [IDX_W-1:0]  w_unused_ptr;

  sprite_draw_scheduler_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req       (i_req_valid),
    .i_advance   (w_take),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_ptr       (w_unused_ptr)
  );

  assign w_any_req = |i_req_valid;
  assign w_take    = (r_state == ST_IDLE) && w_any_req;

`ifdef SPRITE_KEY_EN
  // Transparent pixels are dropped here, so they never stall the scan
  assign w_fb_we = r_p1_valid && (i_rom_data != KEY);
`else
  assign w_fb_we = r_p1_valid;
  logic w_unused_key;
  assign w_unused_key = ^KEY;
`endif

  // The pipeline moves whenever the pending write (if any) is accepted
  assign w_advance = !w_fb_we || i_fb_ready;

  // Sequencer: arbitrate in IDLE, scan in RUN, flush last pixel in DRAIN, pulse done in DONE
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_req_done <= '0;
      r_busy     <= 1'b0;
      r_color    <= COLOR_RED;
      r_number   <= '0;
      r_base_x   <= '0;
      r_base_y   <= '0;
      r_addr     <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_p1_valid <= 1'b0;
      r_p1_addr  <= '0;
      r_fb_x     <= '0;
      r_fb_y     <= '0;
    end else begin
      r_req_done <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_state  <= ST_RUN;
            r_busy   <= 1'b1;
            r_grant  <= w_grant;
            r_color  <= color_e'(w_req_color[w_grant_idx]);
            r_number <= w_req_number[w_grant_idx];
            r_base_x <= w_req_x[w_grant_idx];
            r_base_y <= w_req_y[w_grant_idx];
            r_addr   <= '0;
            r_col    <= '0;
            r_row    <= '0;
          end
        end
        ST_RUN: begin
          if (w_advance) begin
            // Move the issued address into p1; coordinates wrap at the framebuffer width
            r_p1_valid <= 1'b1;
            r_p1_addr  <= r_addr;
            r_fb_x     <= r_base_x + X_W'(r_col);
            r_fb_y     <= r_base_y + Y_W'(r_row);
            if (r_addr == ADDR_LAST) begin
              r_state <= ST_DRAIN;
            end else begin
              r_addr <= r_addr + 1'b1;
              if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
              end else begin
                r_col <= r_col + 1'b1;
              end
            end
          end
        end
        ST_DRAIN: begin
          if (w_advance) begin
            r_p1_valid <= 1'b0;
            r_state    <= ST_DONE;
            r_req_done <= r_grant;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // On a stall the ROM is re-addressed with p1's pixel so its data stays put
  assign o_rom_addr   = w_advance ? r_addr : r_p1_addr;
  assign o_rom_color  = r_color;
  assign o_rom_number = r_number;
  assign o_req_done   = r_req_done;
  assign o_busy       = r_busy;
  assign o_fb_we      = w_fb_we;
  assign o_fb_x       = r_fb_x;
  assign o_fb_y       = r_fb_y;
  assign o_fb_data    = w_fb_we ? i_rom_data : '0;

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Bench for sprite_draw_scheduler: a synthetic sprite ROM, a round-robin
// and raster reference model feeding expectation queues, and a monitor
// that scores every framebuffer write and done pulse.
`timescale 1ns/1ps
module tb_sprite_draw_scheduler;

  localparam int N_REQ  = 4;
  localparam int X_W    = 10;
  localparam int Y_W    = 10;
  localparam int ADDR_W = 10;
  localparam int SPR_W  = 30;
  localparam int FRAME  = 900;
  localparam int XMOD   = 1 << X_W;
  localparam int YMOD   = 1 << Y_W;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N_REQ-1:0]     req_valid;
  logic [2*N_REQ-1:0]   req_color;
  logic [2*N_REQ-1:0]   req_number;
  logic [X_W*N_REQ-1:0] req_x;
  logic [Y_W*N_REQ-1:0] req_y;
  logic [N_REQ-1:0]     o_req_done;
  logic [1:0]           o_rom_color;
  logic [1:0]           o_rom_number;
  logic [ADDR_W-1:0]    o_rom_addr;
  logic [7:0]           rom_data = 8'h00;
  logic                 o_fb_we;
  logic                 fb_ready;
  logic [X_W-1:0]       o_fb_x;
  logic [Y_W-1:0]       o_fb_y;
  logic [7:0]           o_fb_data;
  logic                 o_busy;

  always #5 clk = ~clk;

  sprite_draw_scheduler dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .i_req_color  (req_color),
    .i_req_number (req_number),
    .i_req_x      (req_x),
    .i_req_y      (req_y),
    .o_req_done   (o_req_done),
    .o_rom_color  (o_rom_color),
    .o_rom_number (o_rom_number),
    .o_rom_addr   (o_rom_addr),
    .i_rom_data   (rom_data),
    .o_fb_we      (o_fb_we),
    .i_fb_ready   (fb_ready),
    .o_fb_x       (o_fb_x),
    .o_fb_y       (o_fb_y),
    .o_fb_data    (o_fb_data),
    .o_busy       (o_busy)
  );

  // Synthetic ROM contents: every third pixel is the transparent value 0
  function automatic int rom_pix(input int c, input int n, input int a);
    if (a % 3 == 0) return 0;
    return ((a * 7 + c * 53 + n * 17) % 255) + 1;
  endfunction

  // Registered-read ROM model
  always @(posedge clk) begin
    rom_data <= 8'(rom_pix(int'(o_rom_color), int'(o_rom_number), int'(o_rom_addr)));
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state and expectation queues
  typedef struct { int x; int y; int d; } wr_t;
  typedef struct { int r; int c; int n; int nw; } spr_t;
  wr_t  exp_wr[$];
  spr_t exp_spr[$];
  int   exp_done[$];
  int   rr_ptr = 0;

  function automatic int rr_pick(input logic [N_REQ-1:0] mask);
    for (int i = 0; i < N_REQ; i++) begin
      int idx = (rr_ptr + i) % N_REQ;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  // Expected raster of one sprite: row-major, coordinates modulo framebuffer size
  task automatic push_sprite(input int r, input int c, input int n, input int x, input int y,
                             output int first_addr);
    spr_t s;
    int nw = 0;
    first_addr = -1;
    for (int a = 0; a < FRAME; a++) begin
      wr_t w;
      int d = rom_pix(c, n, a);
`ifdef SPRITE_KEY_EN
      if (d == 0) continue;
`endif
      if (first_addr < 0) first_addr = a;
      w.x = (x + a % SPR_W) % XMOD;
      w.y = (y + a / SPR_W) % YMOD;
      w.d = d;
      exp_wr.push_back(w);
      nw++;
    end
    s.r = r; s.c = c; s.n = n; s.nw = nw;
    exp_spr.push_back(s);
    exp_done.push_back(r);
  endtask

  task automatic load_req(input int r, input int c, input int n, input int x, input int y);
    req_color[2*r +: 2]     = 2'(c);
    req_number[2*r +: 2]    = 2'(n);
    req_x[X_W*r +: X_W]     = X_W'(x);
    req_y[Y_W*r +: Y_W]     = Y_W'(y);
  endtask

  // Ready generator: always high, or pseudo-random when rand_ready is set
  bit rand_ready = 1'b0;
  initial begin
    fb_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      fb_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: scores writes, done pulses, ROM selects and stall stability
  int n_xfer       = 0;
  bit mark_we      = 1'b0;
  int first_we_cyc = -1;
  initial begin : monitor
    bit   prev_stall;
    int   prev_x, prev_y, prev_d;
    int   wr_in_spr;
    wr_t  w;
    int   r;
    prev_stall = 1'b0;
    prev_x = 0; prev_y = 0; prev_d = 0;
    wr_in_spr = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        wr_in_spr  = 0;
        continue;
      end
      if (prev_stall) begin
        check("stall_hold_we", o_fb_we, 1);
        check("stall_hold_x", o_fb_x, prev_x);
        check("stall_hold_y", o_fb_y, prev_y);
        check("stall_hold_data", o_fb_data, prev_d);
      end
      prev_stall = o_fb_we && !fb_ready;
      prev_x = o_fb_x; prev_y = o_fb_y; prev_d = o_fb_data;
      if (mark_we && o_fb_we) begin
        first_we_cyc = cyc;
        mark_we = 1'b0;
      end
      if (o_busy && exp_spr.size() > 0) begin
        check("rom_color", o_rom_color, exp_spr[0].c);
        check("rom_number", o_rom_number, exp_spr[0].n);
      end
      if (o_fb_we && fb_ready) begin
        n_xfer++;
        wr_in_spr++;
        if (exp_wr.size() == 0) begin
          check("unexpected_write", o_fb_we, 0);
        end else begin
          w = exp_wr.pop_front();
          check("fb_x", o_fb_x, w.x);
          check("fb_y", o_fb_y, w.y);
          check("fb_data", o_fb_data, w.d);
        end
      end
      if (o_req_done != '0) begin
        if (exp_done.size() == 0) begin
          check("unexpected_done", o_req_done, 0);
        end else begin
          r = exp_done.pop_front();
          check("req_done", o_req_done, 1 << r);
          if (exp_spr.size() > 0) begin
            check("sprite_writes", wr_in_spr, exp_spr[0].nw);
            $display("sprite done: req %0d color %0d num %0d writes %0d cycle %0d",
                     r, exp_spr[0].c, exp_spr[0].n, wr_in_spr, cyc);
            void'(exp_spr.pop_front());
          end
        end
        wr_in_spr = 0;
      end
    end
  end

  // Wait for n done pulses, then withdraw every request at once
  task automatic wait_done(input int n, input int budget, output int last_cyc);
    int seen = 0;
    int k = 0;
    last_cyc = -1;
    while (seen < n && k < budget) begin
      @(posedge clk);
      #1;
      k++;
      if (o_req_done != '0) begin
        seen++;
        last_cyc = cyc;
      end
    end
    req_valid = '0;
    if (seen < n) check("done_timeout", seen, n);
  endtask

  // Issue a single request and check the first-cycle outputs of the draw
  task automatic single_draw(input int r, input int c, input int n, input int x, input int y,
                             input bit timing_chk);
    int g, fa, t0, dc;
    g = rr_pick(N_REQ'(1 << r));
    rr_ptr = (g + 1) % N_REQ;
    push_sprite(g, c, n, x, y, fa);
    load_req(r, c, n, x, y);
    mark_we = 1'b1;
    @(posedge clk);
    #1;
    req_valid = N_REQ'(1 << r);
    t0 = cyc;
    @(negedge clk);
    @(negedge clk);
    check("first_rom_addr", o_rom_addr, 0);
    check("first_busy", o_busy, 1);
    check("first_rom_color", o_rom_color, c);
    check("first_rom_number", o_rom_number, n);
    wait_done(1, 4000, dc);
    if (timing_chk) begin
      check("first_write_cycle", first_we_cyc - t0, 2 + fa);
      check("done_cycle", dc - t0, 902);
    end
  endtask

  initial begin : stim
    int pc[N_REQ], pn[N_REQ], px[N_REQ], py[N_REQ];
    int g, fa, dc, base, k;

    rst = 1'b1;
    req_valid = '0;
    req_color = '0; req_number = '0; req_x = '0; req_y = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_fb_we", o_fb_we, 0);
    check("rst_req_done", o_req_done, 0);
    check("rst_busy", o_busy, 0);
    check("rst_rom_addr", o_rom_addr, 0);
    check("rst_fb_x", o_fb_x, 0);
    check("rst_fb_y", o_fb_y, 0);
    check("rst_fb_data", o_fb_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rr_ptr = 0;

    // Single blue 3 at (100,50) with the framebuffer always ready
    single_draw(0, 2, 3, 100, 50, 1'b1);

    // All four requesters held: round-robin order under random backpressure
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rr_ptr = 0;
    for (int r = 0; r < N_REQ; r++) begin
      pc[r] = $urandom_range(0, 3);
      pn[r] = $urandom_range(0, 3);
      px[r] = $urandom_range(0, XMOD - 1);
      py[r] = $urandom_range(0, YMOD - 1);
      load_req(r, pc[r], pn[r], px[r], py[r]);
    end
    for (int s = 0; s < 5; s++) begin
      g = rr_pick('1);
      rr_ptr = (g + 1) % N_REQ;
      push_sprite(g, pc[g], pn[g], px[g], py[g], fa);
    end
    rand_ready = 1'b1;
    req_valid = '1;
    wait_done(5, 20000, dc);
    rand_ready = 1'b0;

    // Reset in the middle of a sprite, then a fresh request from address 0
    load_req(1, 1, 2, 300, 200);
    g = rr_pick(4'b0010);
    rr_ptr = (g + 1) % N_REQ;
    push_sprite(g, 1, 2, 300, 200, fa);
    base = n_xfer;
    k = 0;
    req_valid = 4'b0010;
    while ((n_xfer - base) < 400 && k < 3000) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("pixels_before_reset", n_xfer - base, 400);
    rst = 1'b1;
    req_valid = '0;
    exp_wr.delete();
    exp_spr.delete();
    exp_done.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    rr_ptr = 0;
    @(negedge clk);
    check("post_rst_fb_we", o_fb_we, 0);
    check("post_rst_busy", o_busy, 0);
    check("post_rst_req_done", o_req_done, 0);
    single_draw(2, 0, 1, 17, 900, 1'b1);

    // Sprite straddling the right edge: x wraps modulo 1024, random backpressure
    rand_ready = 1'b1;
    single_draw(3, 3, 0, 1020, 0, 1'b0);
    rand_ready = 1'b0;

    repeat (5) @(posedge clk);
    #1;
    check("leftover_writes", exp_wr.size(), 0);
    check("leftover_done", exp_done.size(), 0);
    check("idle_busy", o_busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
